// File: rtl/cpa_pkg.sv
// Shared constants and helpers for the shared carry-propagate adder slice.
package cpa_pkg;

  localparam int CPA_N      = 40;
  localparam int CPA_NREQ   = 4;
  // Width of one requester's slice in the packed req_a/req_b buses.
  localparam int CPA_SLICE_W = CPA_N;

  // Ceiling log2, never below 1, so a tag field always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/cpa_block.sv
// Plain N-bit carry-propagate adder with carry-in; carry-out is discarded.
module cpa_block #(
  parameter int N = 40
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum
);

  assign sum = a + b + {{(N-1){1'b0}}, cin};

endmodule

// File: rtl/cpa_share_arbiter.sv
// Round-robin sharing of one cpa_block among NREQ requesters, with an
// operand register and a result register so one add can retire per cycle.
module cpa_share_arbiter
  import cpa_pkg::*;
#(
  parameter int  N    = CPA_N,
  parameter int  NREQ = CPA_NREQ,
  localparam int IDW  = clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_sum,
  output logic [IDW-1:0]    res_id,
  output logic              busy
);

  logic [IDW-1:0] ptr_reg;
  logic           s1_v_reg;
  logic [N-1:0]   s1_a_reg;
  logic [N-1:0]   s1_b_reg;
  logic [IDW-1:0] s1_id_reg;
  logic           res_valid_reg;
  logic [N-1:0]   res_sum_reg;
  logic [IDW-1:0] res_id_reg;

  logic           s2_adv;
  logic           s1_adv;
  logic           accept_en;
  logic           accept;
  logic [IDW-1:0] gnt;
  logic           gnt_found;
  logic [IDW-1:0] ptr_next;
  logic [N-1:0]   cpa_sum;

  logic [IDW-1:0] scan_idx [NREQ];
  logic [N-1:0]   a_slice  [NREQ];
  logic [N-1:0]   b_slice  [NREQ];

  assign s2_adv    = !res_valid_reg | res_ready;
  assign s1_adv    = s1_v_reg & s2_adv;
  assign accept_en = (!s1_v_reg | s1_adv) & !rst;
  assign accept    = accept_en & gnt_found;

  // scan_idx[k] is ptr+k with an explicit wrap, so non-power-of-2 NREQ works.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      logic [IDW:0] scan_sum;
      assign scan_sum     = {1'b0, ptr_reg} + (IDW+1)'(gi);
      assign scan_idx[gi] = (scan_sum >= (IDW+1)'(NREQ))
                            ? IDW'(scan_sum - (IDW+1)'(NREQ))
                            : scan_sum[IDW-1:0];
      assign a_slice[gi]   = req_a[gi*N +: N];
      assign b_slice[gi]   = req_b[gi*N +: N];
      assign req_ready[gi] = accept & (gnt == IDW'(gi));
    end
  endgenerate

  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && req_valid[scan_idx[k]]) begin
        gnt       = scan_idx[k];
        gnt_found = 1'b1;
      end
    end
  end

  assign ptr_next = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);

  cpa_block #(
    .N (N)
  ) u_cpa (
    .a   (s1_a_reg),
    .b   (s1_b_reg),
    .cin (1'b0),
    .sum (cpa_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= '0;
      s1_v_reg      <= 1'b0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_id_reg     <= '0;
      res_valid_reg <= 1'b0;
      res_sum_reg   <= '0;
      res_id_reg    <= '0;
    end else begin
      // Stage 1 refills in the same cycle it hands its operands onward.
      if (accept) begin
        s1_v_reg  <= 1'b1;
        s1_a_reg  <= a_slice[gnt];
        s1_b_reg  <= b_slice[gnt];
        s1_id_reg <= gnt;
        ptr_reg   <= ptr_next;
      end else if (s1_adv) begin
        s1_v_reg  <= 1'b0;
      end

      if (s1_adv) begin
        res_valid_reg <= 1'b1;
        res_sum_reg   <= cpa_sum;
        res_id_reg    <= s1_id_reg;
      end else if (res_ready) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign res_valid = res_valid_reg;
  assign res_sum   = res_sum_reg;
  assign res_id    = res_id_reg;
  assign busy      = s1_v_reg | res_valid_reg;

endmodule

// File: tb/tb_cpa_share_arbiter.sv
// Directed bench for cpa_share_arbiter: handshake, round-robin order,
// backpressure, wrap-around arithmetic and mid-flight reset.
module tb_cpa_share_arbiter;
  import cpa_pkg::*;

  localparam int N    = CPA_SLICE_W;
  localparam int NREQ = CPA_NREQ;
  localparam int IDW  = clog2(NREQ);

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [N-1:0]      res_sum;
  logic [IDW-1:0]    res_id;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  cpa_share_arbiter #(
    .N    (N),
    .NREQ (NREQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      $display("check %s observed=%h expected=%h ok", tag, obs, exp);
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  // One isolated transaction: handshake, two-cycle latency, then drain.
  task automatic single(input string tag, input int i, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [N-1:0] exp_sum);
    set_op(i, a, b);
    req_valid = NREQ'(1 << i);
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(1 << i));
    tick();
    req_valid = '0;
    chk({tag, "_s1_busy"}, 64'(busy), 64'd1);
    chk({tag, "_s1_noval"}, 64'(res_valid), 64'd0);
    tick();
    chk({tag, "_valid"}, 64'(res_valid), 64'd1);
    chk({tag, "_sum"}, 64'(res_sum), 64'(exp_sum));
    chk({tag, "_id"}, 64'(res_id), 64'(i));
    tick();
    chk({tag, "_drained"}, 64'(res_valid), 64'd0);
  endtask

  logic [N-1:0] exp4 [NREQ];
  int           g;

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    tick();
    tick();
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_sum", 64'(res_sum), 64'd0);
    chk("rst_id", 64'(res_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst       = 1'b0;
    req_valid = '0;

    // 1: single request from requester 0, then ptr must point at 1
    single("t1", 0, 40'd5, 40'd7, 40'd12);
    req_valid = 4'b0011;
    #1;
    chk("t1_ptr", 64'(req_ready), 64'b0010);
    req_valid = '0;
    do_reset();

    // 2: full contention, grants 0,1,2,3,0,1 with results in the same order
    for (int i = 0; i < NREQ; i++) begin
      set_op(i, N'((i + 1) * 16), N'(i + 1));
      exp4[i] = N'((i + 1) * 17);
    end
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t2_gnt%0d", k), 64'(req_ready), 64'(1 << (k % 4)));
      tick();
      if (k >= 1) begin
        chk($sformatf("t2_id%0d", k - 1), 64'(res_id), 64'((k - 1) % 4));
        chk($sformatf("t2_sum%0d", k - 1), 64'(res_sum), 64'(exp4[(k - 1) % 4]));
      end
    end
    req_valid = '0;
    tick();
    chk("t2_id5", 64'(res_id), 64'd1);
    chk("t2_sum5", 64'(res_sum), 64'h22);
    tick();
    chk("t2_idle", 64'(res_valid), 64'd0);
    do_reset();

    // 3: only 2 and 3 valid, pointer skips idle 0 and 1 after wrapping
    set_op(2, 40'd1000, 40'd24);
    set_op(3, 40'd7, 40'd9);
    exp4[2] = 40'd1024;
    exp4[3] = 40'd16;
    req_valid = 4'b1100;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 1) ? 3 : 2;
      #1;
      chk($sformatf("t3_gnt%0d", k), 64'(req_ready), 64'(1 << g));
      tick();
      if (k >= 1) begin
        chk($sformatf("t3_id%0d", k - 1), 64'(res_id), 64'((k % 2 == 1) ? 2 : 3));
        chk($sformatf("t3_sum%0d", k - 1), 64'(res_sum), 64'(exp4[(k % 2 == 1) ? 2 : 3]));
      end
    end
    req_valid = '0;
    tick();
    chk("t3_id3", 64'(res_id), 64'd3);
    chk("t3_sum3", 64'(res_sum), 64'd16);
    tick();
    chk("t3_idle", 64'(res_valid), 64'd0);

    // 4: backpressure on a stream from requester 1
    req_valid = 4'b0010;
    set_op(1, 40'd1, 40'h100);
    #1;
    chk("t4_rdy0", 64'(req_ready), 64'b0010);
    tick();
    res_ready = 1'b0;
    set_op(1, 40'd2, 40'h100);
    #1;
    chk("t4_rdy1", 64'(req_ready), 64'b0010);
    tick();
    chk("t4_sum_a", 64'(res_sum), 64'h101);
    set_op(1, 40'd3, 40'h100);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("t4_stall%0d", k), 64'(req_ready), 64'd0);
      tick();
      chk($sformatf("t4_frozen_v%0d", k), 64'(res_valid), 64'd1);
      chk($sformatf("t4_frozen_s%0d", k), 64'(res_sum), 64'h101);
      chk($sformatf("t4_frozen_i%0d", k), 64'(res_id), 64'd1);
    end
    res_ready = 1'b1;
    #1;
    chk("t4_release", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    chk("t4_sum_b", 64'(res_sum), 64'h102);
    tick();
    chk("t4_sum_c", 64'(res_sum), 64'h103);
    chk("t4_valid_c", 64'(res_valid), 64'd1);
    tick();
    chk("t4_drained", 64'(res_valid), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);

    // 5: carry out of the top bit is dropped
    single("t5_max", 0, 40'hFF_FFFF_FFFF, 40'd1, 40'd0);
    single("t5_msb", 0, 40'h80_0000_0000, 40'h80_0000_0000, 40'd0);
    single("t5_mid", 0, 40'h7F_FFFF_FFFF, 40'd1, 40'h80_0000_0000);

    // 6: reset with both stages occupied
    res_ready = 1'b0;
    set_op(0, 40'd1, 40'd1);
    req_valid = 4'b0001;
    tick();
    tick();
    chk("t6_full_v", 64'(res_valid), 64'd1);
    chk("t6_full_busy", 64'(busy), 64'd1);
    rst       = 1'b1;
    res_ready = 1'b1;
    req_valid = '1;
    #1;
    chk("t6_rst_ready", 64'(req_ready), 64'd0);
    tick();
    chk("t6_rst_valid", 64'(res_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_sum", 64'(res_sum), 64'd0);
    rst = 1'b0;
    #1;
    chk("t6_gnt0", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    tick();
    chk("t6_id", 64'(res_id), 64'd0);
    chk("t6_sum", 64'(res_sum), 64'd2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
